// File: rtl/key_entry_pkg.sv
// rtl/key_entry_pkg.sv - keypad codes, key classes, FSM states and the code decoder function
// Shared by key_code_decode and key_entry_buffer; other keypad clients import it too.
package key_entry_pkg;

  localparam int unsigned KEY_1     = 12;
  localparam int unsigned KEY_2     = 13;
  localparam int unsigned KEY_3     = 14;
  localparam int unsigned KEY_4     = 7;
  localparam int unsigned KEY_5     = 8;
  localparam int unsigned KEY_6     = 9;
  localparam int unsigned KEY_7     = 2;
  localparam int unsigned KEY_8     = 3;
  localparam int unsigned KEY_9     = 4;
  localparam int unsigned KEY_0     = 17;
  localparam int unsigned KEY_CLEAR = 15;
  localparam int unsigned KEY_BACK  = 18;
  localparam int unsigned KEY_ENTER = 19;

  localparam logic [3:0] BLANK = 4'hf;

  typedef enum logic [2:0] {KC_NONE, KC_DIGIT, KC_CLEAR, KC_BACK, KC_ENTER} key_class_e;
  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_COMMIT} state_e;

  typedef struct packed {
    key_class_e cls;
    logic [3:0] digit;
  } key_dec_t;

  function automatic key_dec_t decode_key(input logic [31:0] code);
    key_dec_t d;
    d.cls   = KC_DIGIT;
    d.digit = 4'd0;
    case (code)
      KEY_1:     d.digit = 4'd1;
      KEY_2:     d.digit = 4'd2;
      KEY_3:     d.digit = 4'd3;
      KEY_4:     d.digit = 4'd4;
      KEY_5:     d.digit = 4'd5;
      KEY_6:     d.digit = 4'd6;
      KEY_7:     d.digit = 4'd7;
      KEY_8:     d.digit = 4'd8;
      KEY_9:     d.digit = 4'd9;
      KEY_0:     d.digit = 4'd0;
      KEY_CLEAR: d.cls   = KC_CLEAR;
      KEY_BACK:  d.cls   = KC_BACK;
      KEY_ENTER: d.cls   = KC_ENTER;
      default:   d.cls   = KC_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/key_entry_buffer_if.sv
// rtl/key_entry_buffer_if.sv - key strobe input and committed-value valid/ready handshake
// master = keypad scanner / preset consumer side, slave = key_entry_buffer.
interface key_entry_buffer_if #(
  parameter int KEY_W    = 5,
  parameter int N_DIGITS = 4
);
  logic                    i_key_valid;
  logic [KEY_W-1:0]        i_key_value;
  logic                    i_value_ready;
  logic [4*N_DIGITS-1:0]   o_value;
  logic                    o_value_valid;

  modport master (
    output i_key_valid, i_key_value, i_value_ready,
    input  o_value, o_value_valid
  );

  modport slave (
    input  i_key_valid, i_key_value, i_value_ready,
    output o_value, o_value_valid
  );
endinterface

// File: rtl/key_code_decode.sv
// rtl/key_code_decode.sv - registered keypad code decode to {class, digit, strobe}
// One cycle of latency; the class/digit are only meaningful while o_strobe is high.
module key_code_decode
  import key_entry_pkg::*;
#(
  parameter int KEY_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_key_valid,
  input  logic [KEY_W-1:0] i_key_value,
  output logic             o_strobe,
  output key_class_e       o_class,
  output logic [3:0]       o_digit
);

  key_dec_t   w_dec;
  logic       r_strobe;
  key_class_e r_class;
  logic [3:0] r_digit;

  assign w_dec = decode_key(32'(i_key_value));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_strobe <= 1'b0;
      r_class  <= KC_NONE;
      r_digit  <= 4'd0;
    end else begin
      r_strobe <= i_key_valid;
      r_class  <= w_dec.cls;
      r_digit  <= w_dec.digit;
    end
  end

  assign o_strobe = r_strobe;
  assign o_class  = r_class;
  assign o_digit  = r_digit;

endmodule

// File: rtl/key_entry_buffer.sv
// rtl/key_entry_buffer.sv - N-digit keypad entry buffer with ENTER commit over valid/ready
// Optional idle auto-clear in S_ENTRY when KEY_ENTRY_TIMEOUT_EN is defined.
module key_entry_buffer
  import key_entry_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int KEY_W       = 5,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  key_entry_buffer_if.slave     bus,
  output logic [4*N_DIGITS-1:0] o_entry_bcd,
  output logic [3:0]            o_digit_count,
  output logic                  o_err,
  output logic                  o_timeout
);

  localparam int W = 4*N_DIGITS;
  localparam logic [W-1:0] BLANK_ALL = {N_DIGITS{BLANK}};

  logic       w_strobe;
  key_class_e w_class;
  logic [3:0] w_digit;

  key_code_decode #(.KEY_W(KEY_W)) u_decode (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_key_valid (bus.i_key_valid),
    .i_key_value (bus.i_key_value),
    .o_strobe    (w_strobe),
    .o_class     (w_class),
    .o_digit     (w_digit)
  );

  state_e     r_state;
  logic [W-1:0] r_buf;
  logic [3:0] r_count;
  logic [W-1:0] r_value;
  logic       r_value_valid;
  logic       r_err;

  logic [W-1:0] w_shl;
  logic [W-1:0] w_shr;
  logic [W-1:0] w_commit;

  // Unused upper digits are always blank, so one left shift serves both first load and append.
  assign w_shl = (r_buf << 4) | W'(w_digit);
  assign w_shr = (r_buf >> 4) | (BLANK_ALL & ~(BLANK_ALL >> 4));

  always_comb begin
    w_commit = '0;
    for (int i = 0; i < N_DIGITS; i++)
      w_commit[4*i +: 4] = (r_buf[4*i +: 4] == BLANK) ? 4'h0 : r_buf[4*i +: 4];
  end

`ifdef KEY_ENTRY_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] r_idle;
  logic             r_timeout;
  logic             w_expire;
  assign w_expire = (r_idle == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state       <= S_IDLE;
      r_buf         <= BLANK_ALL;
      r_count       <= 4'd0;
      r_value       <= '0;
      r_value_valid <= 1'b0;
      r_err         <= 1'b0;
`ifdef KEY_ENTRY_TIMEOUT_EN
      r_idle        <= '0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      r_err <= 1'b0;
`ifdef KEY_ENTRY_TIMEOUT_EN
      // Any key, accepted or rejected, restarts the idle count; only a quiet S_ENTRY advances it.
      r_idle    <= '0;
      r_timeout <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_strobe) begin
            if (w_class == KC_DIGIT) begin
              r_buf   <= w_shl;
              r_count <= 4'd1;
              r_state <= S_ENTRY;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_ENTRY: begin
          if (w_strobe) begin
            unique case (w_class)
              KC_DIGIT: begin
                if (r_count < 4'(N_DIGITS)) begin
                  r_buf   <= w_shl;
                  r_count <= r_count + 4'd1;
                end else begin
                  r_err <= 1'b1;
                end
              end
              KC_BACK: begin
                r_buf   <= w_shr;
                r_count <= r_count - 4'd1;
                if (r_count == 4'd1) r_state <= S_IDLE;
              end
              KC_CLEAR: begin
                r_buf   <= BLANK_ALL;
                r_count <= 4'd0;
                r_state <= S_IDLE;
              end
              KC_ENTER: begin
                r_value       <= w_commit;
                r_value_valid <= 1'b1;
                r_buf         <= BLANK_ALL;
                r_count       <= 4'd0;
                r_state       <= S_COMMIT;
              end
              default: r_err <= 1'b1;
            endcase
          end
`ifdef KEY_ENTRY_TIMEOUT_EN
          else if (w_expire) begin
            r_buf     <= BLANK_ALL;
            r_count   <= 4'd0;
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
`endif
        end
        S_COMMIT: begin
          // CLEAR withdraws the offer without touching o_value; other keys are dropped.
          if (bus.i_value_ready || (w_strobe && w_class == KC_CLEAR)) begin
            r_value_valid <= 1'b0;
            r_state       <= S_IDLE;
          end
          if (w_strobe && w_class != KC_CLEAR) r_err <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_entry_bcd       = r_buf;
  assign o_digit_count     = r_count;
  assign o_err             = r_err;
  assign bus.o_value       = r_value;
  assign bus.o_value_valid = r_value_valid;
`ifdef KEY_ENTRY_TIMEOUT_EN
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_key_entry_buffer.sv
// tb/tb_key_entry_buffer.sv - directed keypad sequences against a digit-queue model of key_entry_buffer
// Exercises the timeout path only when KEY_ENTRY_TIMEOUT_EN is defined.
module tb_key_entry_buffer;

  localparam int N  = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] o_entry_bcd;
  logic [3:0]  o_digit_count;
  logic        o_err;
  logic        o_timeout;

  int n_chk = 0;
  int n_err = 0;

  key_entry_buffer_if #(.KEY_W(5), .N_DIGITS(N)) bus ();

  key_entry_buffer #(.N_DIGITS(N), .KEY_W(5), .TIMEOUT_CYC(TO)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .bus           (bus),
    .o_entry_bcd   (o_entry_bcd),
    .o_digit_count (o_digit_count),
    .o_err         (o_err),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: held digits as a queue (oldest first), a pending-offer flag and a two-edge key delay.
  int          m_q[$];
  bit          m_pending;
  logic [15:0] m_value;
  bit          m_err, m_to;
  int          m_idle;
  bit          p_v;
  int          p_k;

  function automatic int key_digit(input int code);
    case (code)
      12: return 1;  13: return 2;  14: return 3;
      7:  return 4;  8:  return 5;  9:  return 6;
      2:  return 7;  3:  return 8;  4:  return 9;
      17: return 0;
      default: return -1;
    endcase
  endfunction

  function automatic logic [15:0] exp_entry();
    logic [15:0] r;
    r = 16'hffff;
    for (int i = 0; i < m_q.size(); i++) r[4*i +: 4] = 4'(m_q[m_q.size()-1-i]);
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_q.delete(); m_pending = 0; m_value = 0; m_err = 0; m_to = 0;
      m_idle = 0; p_v = 0; p_k = 0;
    end else begin
      int d;
      m_err = 0; m_to = 0;
      if (m_pending) begin
        if ((p_v && p_k == 15) || bus.i_value_ready) m_pending = 0;
        if (p_v && p_k != 15) m_err = 1;
      end else if (p_v) begin
        d = key_digit(p_k);
        m_idle = 0;
        if (d >= 0) begin
          if (m_q.size() < N) m_q.push_back(d);
          else m_err = 1;
        end else if (p_k == 18 && m_q.size() > 0) m_q.pop_back();
        else if (p_k == 15 && m_q.size() > 0) m_q.delete();
        else if (p_k == 19 && m_q.size() > 0) begin
          m_value = 0;
          foreach (m_q[i]) m_value = (m_value << 4) | 16'(m_q[i]);
          m_pending = 1;
          m_q.delete();
        end else m_err = 1;
      end
`ifdef KEY_ENTRY_TIMEOUT_EN
      else if (m_q.size() > 0) begin
        if (m_idle == TO - 1) begin
          m_q.delete();
          m_to = 1;
          m_idle = 0;
        end else m_idle++;
      end
`endif
      p_v = bus.i_key_valid;
      p_k = int'(bus.i_key_value);
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      check("entry_bcd", 32'(o_entry_bcd), 32'(exp_entry()));
      check("digit_count", 32'(o_digit_count), 32'(m_q.size()));
      check("value", 32'(bus.o_value), 32'(m_value));
      check("value_valid", 32'(bus.o_value_valid), 32'(m_pending));
      check("err", 32'(o_err), 32'(m_err));
      check("timeout", 32'(o_timeout), 32'(m_to));
    end
  end

  task automatic press(input int code);
    @(posedge clk); #1;
    bus.i_key_valid = 1'b1;
    bus.i_key_value = 5'(code);
    @(posedge clk); #1;
    bus.i_key_valid = 1'b0;
  endtask

  task automatic burst(input int codes[$]);
    foreach (codes[i]) begin
      @(posedge clk); #1;
      bus.i_key_valid = 1'b1;
      bus.i_key_value = 5'(codes[i]);
    end
    @(posedge clk); #1;
    bus.i_key_valid = 1'b0;
  endtask

  // After press/burst: move past the edge where the last key lands in the buffer.
  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int seen;
    bus.i_key_valid   = 1'b0;
    bus.i_key_value   = 5'd0;
    bus.i_value_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_entry", 32'(o_entry_bcd), 32'h0000ffff);
    check("rst_count", 32'(o_digit_count), 32'd0);
    check("rst_valid", 32'(bus.o_value_valid), 32'd0);
    #2 rstn = 1'b1;

    // 1: 1234 then ENTER, offer appears two edges after the strobe
    press(12); press(13); press(14); press(7); settle();
    check("t1_entry", 32'(o_entry_bcd), 32'h1234);
    check("t1_count", 32'(o_digit_count), 32'd4);
    press(19);
    @(negedge clk);
    check("t1_valid_early", 32'(bus.o_value_valid), 32'd0);
    @(negedge clk);
    check("t1_valid", 32'(bus.o_value_valid), 32'd1);
    check("t1_value", 32'(bus.o_value), 32'h1234);
    check("t1_blank", 32'(o_entry_bcd), 32'hffff);
    @(posedge clk); #1 bus.i_value_ready = 1'b1;
    @(posedge clk); #1 bus.i_value_ready = 1'b0;
    @(negedge clk);
    check("t1_drop", 32'(bus.o_value_valid), 32'd0);
    check("t1_hold", 32'(bus.o_value), 32'h1234);

    // 2: fifth digit rejected, no wrap
    press(12); press(13); press(14); press(7); press(8); settle();
    check("t2_err", 32'(o_err), 32'd1);
    check("t2_entry", 32'(o_entry_bcd), 32'h1234);
    check("t2_count", 32'(o_digit_count), 32'd4);
    press(15); settle();

    // 3: 5,0 then BACK twice, then BACK on empty
    press(8); press(17); settle();
    check("t3_entry50", 32'(o_entry_bcd), 32'hff50);
    press(18); settle();
    check("t3_back1", 32'(o_entry_bcd), 32'hfff5);
    press(18); settle();
    check("t3_back2", 32'(o_entry_bcd), 32'hffff);
    check("t3_count", 32'(o_digit_count), 32'd0);
    press(18); settle();
    check("t3_err", 32'(o_err), 32'd1);

    // 4: 6 then ENTER, ready held low, keys during the offer are rejected
    press(9); press(19); settle();
    check("t4_value", 32'(bus.o_value), 32'h0006);
    repeat (3) @(negedge clk);
    press(12); settle();
    check("t4_err", 32'(o_err), 32'd1);
    check("t4_still", 32'(bus.o_value_valid), 32'd1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 bus.i_value_ready = 1'b1;
    @(posedge clk); #1 bus.i_value_ready = 1'b0;
    @(negedge clk);
    check("t4_drop", 32'(bus.o_value_valid), 32'd0);

    // one-cycle transfer with ready already high
    bus.i_value_ready = 1'b1;
    press(7); press(19);
    @(negedge clk); @(negedge clk);
    check("t4b_valid", 32'(bus.o_value_valid), 32'd1);
    check("t4b_value", 32'(bus.o_value), 32'h0004);
    @(negedge clk);
    check("t4b_drop", 32'(bus.o_value_valid), 32'd0);
    bus.i_value_ready = 1'b0;

    // CLEAR withdraws the offer, value holds; rejected code and back-to-back keys
    press(13); press(19); settle();
    press(15); settle();
    check("t4c_withdraw", 32'(bus.o_value_valid), 32'd0);
    check("t4c_hold", 32'(bus.o_value), 32'h0002);
    press(0); settle();
    check("t4c_badkey", 32'(o_err), 32'd1);
    burst('{2, 3, 4, 17, 18, 5}); settle();
    check("t4c_burst", 32'(o_entry_bcd), 32'hf789);
    press(15); settle();

`ifdef KEY_ENTRY_TIMEOUT_EN
    // 5: idle timeout 16 cycles after the digit lands; a key on the expiry edge wins
    press(13); settle();
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (o_timeout && seen == 0) seen = k;
    end
    check("t5_delay", 32'(seen), 32'd16);
    check("t5_blank", 32'(o_entry_bcd), 32'hffff);
    press(13); settle();
    repeat (14) @(posedge clk);
    #1 bus.i_key_valid = 1'b1; bus.i_key_value = 5'd14;
    @(posedge clk); #1 bus.i_key_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t5_keywins", 32'(o_timeout), 32'd0);
    check("t5_entry", 32'(o_entry_bcd), 32'hff23);
    repeat (20) @(negedge clk);
    check("t5_expired", 32'(o_digit_count), 32'd0);
`else
    seen = 0;
    press(13); settle();
    repeat (TO + 4) begin
      @(negedge clk);
      if (o_timeout) seen++;
    end
    check("t5_no_timeout", 32'(seen), 32'd0);
    check("t5_held", 32'(o_entry_bcd), 32'hfff2);
    press(15); settle();
`endif

    // 6: asynchronous reset in the middle of an offer
    press(9); press(19); settle();
    check("t6_pending", 32'(bus.o_value_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("t6_entry", 32'(o_entry_bcd), 32'hffff);
    check("t6_count", 32'(o_digit_count), 32'd0);
    check("t6_valid", 32'(bus.o_value_valid), 32'd0);
    check("t6_value", 32'(bus.o_value), 32'd0);
    check("t6_err", 32'(o_err), 32'd0);
    @(negedge clk); #2 rstn = 1'b1;
    press(4); settle();
    check("t6_after", 32'(o_entry_bcd), 32'hfff9);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
